// File: rtl/exe_defs_pkg.sv
`default_nettype none
// exe_defs: ALU opcodes, memory access type codes, extended register addresses and divider states.
// Revision 1.0
package exe_defs;

   localparam logic [3:0] C_ALU_AND  = 4'h0;
   localparam logic [3:0] C_ALU_OR   = 4'h1;
   localparam logic [3:0] C_ALU_ADD  = 4'h2;
   localparam logic [3:0] C_ALU_SUB  = 4'h3;
   localparam logic [3:0] C_ALU_SLT  = 4'h4;
   localparam logic [3:0] C_ALU_SLTU = 4'h5;
   localparam logic [3:0] C_ALU_SLL  = 4'h6;
   localparam logic [3:0] C_ALU_SRL  = 4'h7;
   localparam logic [3:0] C_ALU_SAL  = 4'h8;
   localparam logic [3:0] C_ALU_SRA  = 4'h9;
   localparam logic [3:0] C_ALU_LUI  = 4'hA;
   localparam logic [3:0] C_ALU_XOR  = 4'hB;
   localparam logic [3:0] C_ALU_NOR  = 4'hC;

   localparam logic [2:0] C_TYPE_NONE = 3'b111;

   localparam logic [5:0] C_REG_LO        = 6'd32;
   localparam logic [5:0] C_REG_HI        = 6'd33;
   localparam logic [5:0] C_REG_CP0_FIRST = 6'd44;
   localparam logic [5:0] C_REG_CP0_LAST  = 6'd46;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } div_state_t;

endpackage
`default_nettype wire

// File: rtl/div_iter.sv
`default_nettype none
// div_iter: iterative radix-2 restoring divider, one quotient bit per cycle, with sign fixup.
// Revision 1.0
module div_iter
   import exe_defs::*;
#(
   parameter int DIV_CYCLES = 32
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic        is_signed,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] q,
   output logic [31:0] r
);

   localparam logic [5:0] C_LAST_STEP = 6'(DIV_CYCLES - 1);

   div_state_t  r_state;
   div_state_t  w_state_nxt;
   logic [5:0]  r_count;
   logic [63:0] r_rem_quo;
   logic [31:0] r_divisor;
   logic        r_q_neg;
   logic        r_r_neg;

   logic [31:0] w_a_abs;
   logic [31:0] w_b_abs;
   logic [32:0] w_partial;
   logic [32:0] w_diff;
   logic        w_fits;
   logic [31:0] w_q_raw;
   logic [31:0] w_r_raw;

   assign w_a_abs = (is_signed && a[31]) ? (32'h0 - a) : a;
   assign w_b_abs = (is_signed && b[31]) ? (32'h0 - b) : b;

   // Upper half shifted left by one with the next dividend bit appended; 33 bits so no carry is lost.
   assign w_partial = r_rem_quo[63:31];
   assign w_diff    = w_partial - {1'b0, r_divisor};
   assign w_fits    = w_partial >= {1'b0, r_divisor};

   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         DIV_IDLE: begin
            if (start) w_state_nxt = DIV_BUSY;
         end
         DIV_BUSY: begin
            busy = 1'b1;
            if (r_count == C_LAST_STEP) w_state_nxt = DIV_DONE;
         end
         DIV_DONE: begin
            done        = 1'b1;
            w_state_nxt = DIV_IDLE;
         end
         default: w_state_nxt = DIV_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= DIV_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_count   <= 6'd0;
         r_rem_quo <= 64'h0;
         r_divisor <= 32'h0;
         r_q_neg   <= 1'b0;
         r_r_neg   <= 1'b0;
      end else begin
         if (r_state == DIV_IDLE && start) begin
            r_count   <= 6'd0;
            r_rem_quo <= {32'h0, w_a_abs};
            r_divisor <= w_b_abs;
            r_q_neg   <= is_signed & (a[31] ^ b[31]);
            r_r_neg   <= is_signed & a[31];
         end else if (r_state == DIV_BUSY) begin
            r_count <= r_count + 6'd1;
            if (w_fits) begin
               r_rem_quo <= {w_diff[31:0], r_rem_quo[30:0], 1'b1};
            end else begin
               r_rem_quo <= {w_partial[31:0], r_rem_quo[30:0], 1'b0};
            end
         end
      end
   end

   assign w_q_raw = r_rem_quo[31:0];
   assign w_r_raw = r_rem_quo[63:32];
   assign q       = r_q_neg ? (32'h0 - w_q_raw) : w_q_raw;
   assign r       = r_r_neg ? (32'h0 - w_r_raw) : w_r_raw;

endmodule
`default_nettype wire

// File: rtl/execute_stage.sv
`default_nettype none
// execute_stage: ALU, single-cycle multiplier, iterative divider, HI/LO write and mem-stage registers.
// Revision 1.0
module execute_stage
   import exe_defs::*;
#(
   parameter int DIV_CYCLES = 32
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [3:0]  de_aluop,
   input  logic [31:0] de_alusrc1,
   input  logic [31:0] de_alusrc2,
   input  logic        de_mult_en,
   input  logic        de_div_en,
   input  logic        de_is_signed,
   input  logic [31:0] de_MD_src1,
   input  logic [31:0] de_MD_src2,
   input  logic        de_mem_en,
   input  logic        de_mem_read,
   input  logic        de_reg_en,
   input  logic [2:0]  de_store_type,
   input  logic [2:0]  de_load_type,
   input  logic [5:0]  de_reg_waddr,
   input  logic [31:0] de_store_rt_data,
   input  logic [31:0] de_load_rt_data,
   output logic        exe_stall,
   output logic [31:0] exe_result,
   output logic        exe_hilo_we,
   output logic [31:0] exe_hi,
   output logic [31:0] exe_lo,
   output logic        exe_mem_en,
   output logic        exe_mem_read,
   output logic        exe_reg_en,
   output logic [2:0]  exe_store_type,
   output logic [2:0]  exe_load_type,
   output logic [5:0]  exe_reg_waddr,
   output logic [31:0] exe_store_rt_data,
   output logic [31:0] exe_load_rt_data,
   output logic [31:0] exe_alu_result
);

   logic [31:0] w_alu_result;
   logic [4:0]  w_shamt;
   logic [63:0] w_mul_a;
   logic [63:0] w_mul_b;
   logic [63:0] w_product;
   logic        w_div_busy;
   logic        w_div_done;
   logic        w_div_idle;
   logic [31:0] w_div_q;
   logic [31:0] w_div_r;

   assign w_shamt = de_alusrc1[4:0];

   always_comb begin
      w_alu_result = 32'h0;
      case (de_aluop)
         C_ALU_AND:  w_alu_result = de_alusrc1 & de_alusrc2;
         C_ALU_OR:   w_alu_result = de_alusrc1 | de_alusrc2;
         C_ALU_ADD:  w_alu_result = de_alusrc1 + de_alusrc2;
         C_ALU_SUB:  w_alu_result = de_alusrc1 - de_alusrc2;
         C_ALU_SLT:  w_alu_result = {31'h0, $signed(de_alusrc1) < $signed(de_alusrc2)};
         C_ALU_SLTU: w_alu_result = {31'h0, de_alusrc1 < de_alusrc2};
         C_ALU_SLL:  w_alu_result = de_alusrc2 << w_shamt;
         C_ALU_SRL:  w_alu_result = de_alusrc2 >> w_shamt;
         C_ALU_SAL:  w_alu_result = 32'h0;
         C_ALU_SRA:  w_alu_result = $unsigned($signed(de_alusrc2) >>> w_shamt);
         C_ALU_LUI:  w_alu_result = {de_alusrc2[15:0], 16'h0};
         C_ALU_XOR:  w_alu_result = de_alusrc1 ^ de_alusrc2;
         C_ALU_NOR:  w_alu_result = ~(de_alusrc1 | de_alusrc2);
         default:    w_alu_result = 32'h0;
      endcase
   end

   assign exe_result = w_alu_result;

   // Extending both operands to 64 bits lets one truncated multiply serve signed and unsigned.
   assign w_mul_a   = {{32{de_is_signed & de_MD_src1[31]}}, de_MD_src1};
   assign w_mul_b   = {{32{de_is_signed & de_MD_src2[31]}}, de_MD_src2};
   assign w_product = w_mul_a * w_mul_b;

   div_iter #(
      .DIV_CYCLES (DIV_CYCLES)
   ) u_div (
      .clk       (clk),
      .resetn    (resetn),
      .start     (de_div_en),
      .is_signed (de_is_signed),
      .a         (de_MD_src1),
      .b         (de_MD_src2),
      .busy      (w_div_busy),
      .done      (w_div_done),
      .q         (w_div_q),
      .r         (w_div_r)
   );

   assign w_div_idle = ~(w_div_busy | w_div_done);
   // The div instruction is released from decode in the DONE cycle.
   assign exe_stall  = de_div_en & ~w_div_done;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         exe_hilo_we <= 1'b0;
         exe_hi      <= 32'h0;
         exe_lo      <= 32'h0;
      end else begin
         exe_hilo_we <= 1'b0;
         if (w_div_done) begin
            exe_hilo_we <= 1'b1;
            exe_hi      <= w_div_r;
            exe_lo      <= w_div_q;
         end else if (de_mult_en && w_div_idle) begin
            exe_hilo_we <= 1'b1;
            exe_hi      <= w_product[63:32];
            exe_lo      <= w_product[31:0];
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         exe_mem_en        <= 1'b0;
         exe_mem_read      <= 1'b0;
         exe_reg_en        <= 1'b0;
         exe_store_type    <= C_TYPE_NONE;
         exe_load_type     <= C_TYPE_NONE;
         exe_reg_waddr     <= 6'd0;
         exe_store_rt_data <= 32'h0;
         exe_load_rt_data  <= 32'h0;
         exe_alu_result    <= 32'h0;
      end else begin
         exe_mem_en        <= de_mem_en;
         exe_mem_read      <= de_mem_read;
         exe_reg_en        <= de_reg_en;
         exe_store_type    <= de_store_type;
         exe_load_type     <= de_load_type;
         exe_reg_waddr     <= de_reg_waddr;
         exe_store_rt_data <= de_store_rt_data;
         exe_load_rt_data  <= de_load_rt_data;
         exe_alu_result    <= w_alu_result;
      end
   end

endmodule
`default_nettype wire
